// File: rtl/nanocore_lsu_resp_pkg.sv
// Shared NanoCore types: LSU request/writeback bundles and LSU FSM state.
// Used by nanocore_lsu_resp and nanocore_lsu_ldext.
package NanoCore_pkg;

  localparam int LSU_TIMEOUT_DEFAULT = 255;
  localparam int LSU_UID_W = 8;

  // 87-bit request from the issue stage
  typedef struct packed {
    logic [LSU_UID_W-1:0] uid;
    logic [4:0]           rf_dst;
    logic [31:0]          addr;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 we;
    logic                 is_lb;
    logic                 is_lh;
    logic                 is_lu;
    logic                 is_sb;
    logic                 is_sh;
  } lsu_ctl_t;

  // 46-bit writeback / uid release entry
  typedef struct packed {
    logic                 ready;
    logic [LSU_UID_W-1:0] uid;
    logic [4:0]           rf_dst;
    logic [31:0]          rf_wdata;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RD_WAIT,
    WB
  } lsu_state_t;

endpackage

// File: rtl/nanocore_lsu_ldext.sv
// Load data lane align and sign/zero extend.
// Also reused by the store-to-load forwarder.
module nanocore_lsu_ldext (
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic        is_lb,
  input  logic        is_lh,
  input  logic        is_lu,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    result  = shifted;
    unique case (1'b1)
      is_lb: result = is_lu ? {24'b0, shifted[7:0]}
                            : {{24{shifted[7]}}, shifted[7:0]};
      is_lh: result = is_lu ? {16'b0, shifted[15:0]}
                            : {{16{shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/nanocore_lsu_resp.sv
// LSU responder: one request in flight, dmem bus driver, load extend, wb.
// Optional macro LSU_MISALIGN_CHK_EN aborts misaligned accesses with o_err.
module nanocore_lsu_resp
  import NanoCore_pkg::*;
#(
  parameter int TIMEOUT_CYC = LSU_TIMEOUT_DEFAULT,
  parameter int UID_W       = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  input  lsu_ctl_t    i_req,
  output logic        o_req_ready,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_wstrb,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_valid,
  output wb_entry_t   o_wb,
  input  logic        i_wb_ready,
  output logic        o_busy,
  output logic        o_err
);

  localparam logic [7:0] TO_CNT =
    (TIMEOUT_CYC > 255) ? 8'd255 : 8'(TIMEOUT_CYC);
  localparam bit TO_EN = (TIMEOUT_CYC != 0);

  lsu_state_t       state_q, state_d;
  lsu_ctl_t         hold_q;
  logic [31:0]      res_q, res_d;
  logic [7:0]       cnt_q;
  logic [31:0]      ld_data;
  logic [UID_W-1:0] uid;
  logic             in_req;
  logic             timeout;
  logic             misal;

  assign uid     = hold_q.uid;
  assign in_req  = (state_q == REQ);
  assign timeout = TO_EN && (cnt_q == TO_CNT);

`ifdef LSU_MISALIGN_CHK_EN
  always_comb begin
    misal = 1'b0;
    if (hold_q.we) begin
      if (hold_q.is_sh)      misal = hold_q.addr[0];
      else if (!hold_q.is_sb) misal = |hold_q.addr[1:0];
    end else begin
      if (hold_q.is_lh)      misal = hold_q.addr[0];
      else if (!hold_q.is_lb) misal = |hold_q.addr[1:0];
    end
  end
`else
  logic unused_flags;
  assign misal = 1'b0;
  assign unused_flags = ^{hold_q.is_sb, hold_q.is_sh};
`endif

  nanocore_lsu_ldext u_ldext (
    .rdata  (i_dmem_rdata),
    .off    (hold_q.addr[1:0]),
    .is_lb  (hold_q.is_lb),
    .is_lh  (hold_q.is_lh),
    .is_lu  (hold_q.is_lu),
    .result (ld_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      if (state_q == IDLE && i_req_valid)
        hold_q <= i_req;
      if (state_q == REQ || state_q == RD_WAIT)
        cnt_q <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      else
        cnt_q <= '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    o_req_ready = 1'b0;
    o_dmem_req  = 1'b0;
    o_wb_valid  = 1'b0;
    o_err       = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_req_ready = i_rst_n;
        if (i_req_valid) state_d = REQ;
      end
      REQ: begin
        o_dmem_req = !misal;
        if (misal) begin
          o_err   = 1'b1;
          res_d   = hold_q.addr;
          state_d = WB;
        end else if (i_dmem_gnt) begin
          res_d   = '0;
          state_d = hold_q.we ? WB : RD_WAIT;
        end else if (timeout) begin
          o_err   = 1'b1;
          res_d   = '0;
          state_d = WB;
        end
      end
      RD_WAIT: begin
        if (i_dmem_rvalid) begin
          res_d   = ld_data;
          state_d = WB;
        end else if (timeout) begin
          o_err   = 1'b1;
          res_d   = '0;
          state_d = WB;
        end
      end
      WB: begin
        o_wb_valid = 1'b1;
        if (i_wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_dmem_we    = in_req & hold_q.we;
  assign o_dmem_addr  = in_req ? {hold_q.addr[31:2], 2'b00} : '0;
  assign o_dmem_wdata = in_req ? hold_q.wdata << {hold_q.addr[1:0], 3'b000}
                               : '0;
  assign o_dmem_wstrb = in_req ? hold_q.wstrb : '0;
  assign o_busy       = (state_q != IDLE);

  always_comb begin
    o_wb = '0;
    if (o_wb_valid) begin
      o_wb.ready    = 1'b1;
      o_wb.uid      = uid;
      o_wb.rf_dst   = hold_q.we ? 5'd0 : hold_q.rf_dst;
      o_wb.rf_wdata = res_q;
    end
  end

endmodule

// File: tb/tb_nanocore_lsu_resp.sv
// Directed bench for nanocore_lsu_resp (TIMEOUT_CYC = 4).
// Inputs change and outputs are checked just after the falling edge.
module tb_nanocore_lsu_resp;
  import NanoCore_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  lsu_ctl_t    req = '0;
  logic        req_ready;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        wb_valid;
  wb_entry_t   wb;
  logic        wb_ready = 1'b0;
  logic        busy, err;

  int checks = 0;
  int failures = 0;
  logic [45:0] got;

  always #5 clk = ~clk;

  nanocore_lsu_resp #(.TIMEOUT_CYC(4), .UID_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .i_req(req), .o_req_ready(req_ready),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
    .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
    .o_dmem_wstrb(dmem_wstrb),
    .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata),
    .o_wb_valid(wb_valid), .o_wb(wb), .i_wb_ready(wb_ready),
    .o_busy(busy), .o_err(err)
  );

  always @(posedge clk)
    assert (!(gnt && rvalid)) else $error("illegal gnt+rvalid");

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic lsu_ctl_t mk(
    input logic [7:0] uid, input logic [4:0] dst,
    input logic [31:0] addr, input logic [31:0] wd,
    input logic [3:0] ws, input logic we,
    input logic lb, input logic lh, input logic lu,
    input logic sb, input logic sh);
    lsu_ctl_t r;
    r.uid = uid; r.rf_dst = dst; r.addr = addr;
    r.wdata = wd; r.wstrb = ws; r.we = we;
    r.is_lb = lb; r.is_lh = lh; r.is_lu = lu;
    r.is_sb = sb; r.is_sh = sh;
    return r;
  endfunction

  task automatic run_load(input lsu_ctl_t r, input logic [31:0] rd,
                          output logic [45:0] res);
    logic [31:0] wa;
    wa = {r.addr[31:2], 2'b00};
    @(negedge clk); req_valid = 1'b1; req = r; #1;
    chk("ld_accept_rdy", req_ready, 1'b1);
    @(negedge clk); req_valid = 1'b0; gnt = 1'b1; #1;
    chk("ld_dmem_req", dmem_req, 1'b1);
    chk("ld_addr", dmem_addr, wa);
    chk("ld_we", dmem_we, 1'b0);
    @(negedge clk); gnt = 1'b0; rvalid = 1'b1; rdata = rd; #1;
    chk("ld_rdwait_req", dmem_req, 1'b0);
    chk("ld_rdwait_wbv", wb_valid, 1'b0);
    @(negedge clk); rvalid = 1'b0; wb_ready = 1'b1; #1;
    chk("ld_wbv_3cyc", wb_valid, 1'b1);
    res = wb;
    @(negedge clk); wb_ready = 1'b0; #1;
    chk("ld_back_idle", busy, 1'b0);
  endtask

  initial begin
    // reset
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wbv", wb_valid, 1'b0);
    chk("rst_dreq", dmem_req, 1'b0);
    chk("rst_wb", wb, 46'h0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("post_rst_ready", req_ready, 1'b1);

    // lw
    run_load(mk(8'h12, 5'd5, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0),
             32'hDEADBEEF, got);
    chk("lw_wb", got, {1'b1, 8'h12, 5'd5, 32'hDEADBEEF});

    // lb / lbu at byte 3
    run_load(mk(8'h21, 5'd7, 32'h103, 0, 0, 0, 1, 0, 0, 0, 0),
             32'h80FF0000, got);
    chk("lb_wb", got, {1'b1, 8'h21, 5'd7, 32'hFFFFFF80});
    run_load(mk(8'h22, 5'd8, 32'h103, 0, 0, 0, 1, 0, 1, 0, 0),
             32'h80FF0000, got);
    chk("lbu_wb", got, {1'b1, 8'h22, 5'd8, 32'h00000080});

    // lh at half 1 sign-extends, lhu at half 0 zero-extends
    run_load(mk(8'h23, 5'd9, 32'h302, 0, 0, 0, 0, 1, 0, 0, 0),
             32'h8001_7FFF, got);
    chk("lh_wb", got, {1'b1, 8'h23, 5'd9, 32'hFFFF8001});
    run_load(mk(8'h24, 5'd10, 32'h300, 0, 0, 0, 0, 1, 1, 0, 0),
             32'h1234_F00D, got);
    chk("lhu_wb", got, {1'b1, 8'h24, 5'd10, 32'h0000F00D});

    // sh with writeback stall
    @(negedge clk); req_valid = 1'b1;
    req = mk(8'h33, 5'd3, 32'h202, 32'h0000ABCD, 4'b1100,
             1, 0, 0, 0, 0, 1);
    #1;
    chk("sh_accept", req_ready, 1'b1);
    @(negedge clk);
    req = mk(8'h44, 5'd4, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0);
    gnt = 1'b1; #1;
    chk("sh_dreq", dmem_req, 1'b1);
    chk("sh_we", dmem_we, 1'b1);
    chk("sh_addr", dmem_addr, 32'h200);
    chk("sh_wdata", dmem_wdata, 32'hABCD0000);
    chk("sh_wstrb", dmem_wstrb, 4'b1100);
    @(negedge clk); gnt = 1'b0; #1;
    chk("sh_wbv_2cyc", wb_valid, 1'b1);
    chk("sh_wb", wb, {1'b1, 8'h33, 5'd0, 32'h0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("stall_wb", wb, {1'b1, 8'h33, 5'd0, 32'h0});
      chk("stall_rdy", req_ready, 1'b0);
    end
    @(negedge clk); wb_ready = 1'b1; #1;
    chk("stall_release", wb_valid, 1'b1);
    @(negedge clk); wb_ready = 1'b0; #1;
    chk("next_rdy", req_ready, 1'b1);
    @(negedge clk); req_valid = 1'b0; gnt = 1'b1; #1;
    chk("next_accepted", dmem_req, 1'b1);
    chk("next_addr", dmem_addr, 32'h400);
    @(negedge clk); gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0BADF00D;
    @(negedge clk); rvalid = 1'b0; wb_ready = 1'b1; #1;
    chk("next_wb", wb, {1'b1, 8'h44, 5'd4, 32'h0BADF00D});
    @(negedge clk); wb_ready = 1'b0;

    // timeout: gnt never comes
    req_valid = 1'b1;
    req = mk(8'h55, 5'd6, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("to_no_err", err, 1'b0);
      chk("to_dreq", dmem_req, 1'b1);
      @(negedge clk);
    end
    #1;
    chk("to_err_pulse", err, 1'b1);
    @(negedge clk); #1;
    chk("to_err_once", err, 1'b0);
    chk("to_wb", wb, {1'b1, 8'h55, 5'd6, 32'h0});
    wb_ready = 1'b1;
    @(negedge clk); wb_ready = 1'b0; #1;
    chk("to_idle", busy, 1'b0);

    // reset during RD_WAIT, late rvalid ignored
    @(negedge clk); req_valid = 1'b1;
    req = mk(8'h66, 5'd2, 32'h600, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); req_valid = 1'b0; gnt = 1'b1;
    @(negedge clk); gnt = 1'b0; rst_n = 1'b0; #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_rdy", req_ready, 1'b0);
    chk("mrst_wb", wb, 46'h0);
    @(negedge clk); rst_n = 1'b1; rvalid = 1'b1; rdata = 32'h11111111;
    @(negedge clk); rvalid = 1'b0; #1;
    chk("late_rv_wbv", wb_valid, 1'b0);
    chk("late_rv_busy", busy, 1'b0);
    chk("late_rv_wb", wb, 46'h0);
    run_load(mk(8'h77, 5'd1, 32'h700, 0, 0, 0, 0, 0, 0, 0, 0),
             32'hCAFEF00D, got);
    chk("after_rst_wb", got, {1'b1, 8'h77, 5'd1, 32'hCAFEF00D});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nanocore_lsu_resp.md
Name: nanocore_lsu_resp

Overview:
Responder end of the lsu_ctl_t request interface. It accepts one load/store request from the issue stage and drives it onto the single-port data-memory bus. For loads it aligns and sign/zero-extends the returned word. For every request it returns a wb_entry_t so the scoreboard can release the uid. It sits between the issue/scoreboard logic and the data memory, and holds one request in flight at a time.

Parameters:
TIMEOUT_CYC, 255, cycles to wait for i_dmem_gnt or i_dmem_rvalid before aborting; 0 disables the timeout
UID_W, 8, uid width; must equal wb_entry_t.uid width

Ports:
i_clk  in  1  core clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  1  lsu_ctl_t request valid
i_req  in  87  lsu_ctl_t request
o_req_ready  out  1  request accepted when valid&ready
o_dmem_req  out  1  memory request strobe
o_dmem_we  out  1  write enable
o_dmem_addr  out  32  word-aligned address ({addr[31:2],2'b0})
o_dmem_wdata  out  32  store data, lane-shifted
o_dmem_wstrb  out  4  byte strobes
i_dmem_gnt  in  1  memory accepted request
i_dmem_rvalid  in  1  read data valid
i_dmem_rdata  in  32  read data
o_wb_valid  out  1  writeback valid
o_wb  out  46  wb_entry_t {ready,uid,rf_dst,rf_wdata}
i_wb_ready  in  1  writeback accepted
o_busy  out  1  state != IDLE
o_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous, active-low, on i_rst_n.
- Reset values: all outputs are 0. o_req_ready is also 0 during reset. The FSM is IDLE.
- FSM states: IDLE, REQ, RD_WAIT, WB.
- IDLE:
  - o_req_ready = 1.
  - On valid&ready, capture i_req into a holding register and go to REQ.
- REQ:
  - o_dmem_req = 1. addr/we/wdata/wstrb are driven from the holding register.
  - Store: wdata = wdata << (8*addr[1:0]); wstrb is taken as supplied.
  - On i_dmem_gnt: a store goes to WB with rf_dst = 0 and rf_wdata = 0; a load goes to RD_WAIT.
- RD_WAIT:
  - o_dmem_req = 0.
  - On i_dmem_rvalid: shifted = rdata >> (8*addr[1:0]).
  - Load extension: is_lb takes bits [7:0]; is_lh takes bits [15:0]; otherwise the full word. Zero-extend if is_lu, else sign-extend.
  - Then go to WB. i_dmem_rvalid in the same cycle as i_dmem_gnt is illegal; the bench asserts on it.
- WB:
  - o_wb_valid = 1 with o_wb = {1, uid, rf_dst, data}.
  - Hold all fields stable until i_wb_ready. On valid&ready, go to IDLE.
- Latency, no memory stall:
  - Store: accept→wb_valid is 2 cycles.
  - Load: 3 cycles.
  - No back-to-back bypass; the next request can be accepted the cycle after the wb handshake.
- Timeout: a cycle counter (8 bits, saturating) runs in REQ and RD_WAIT. When the count reaches TIMEOUT_CYC, o_err pulses and the FSM goes to WB with rf_wdata = 0, so the uid is still released.
- Reset mid-operation: the holding register and counter clear. A late i_dmem_rvalid arriving in IDLE is ignored.
- i_req fields are sampled only on the accept handshake. Changes at other times have no effect.

Optional Feature:
LSU_MISALIGN_CHK_EN:
- Defined: in REQ, a misaligned request (lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0) does not assert o_dmem_req. The block goes directly to WB with rf_wdata = addr and pulses o_err.
- Undefined: no check; addressing is lane-shift only, with wrap within the word.

Decomposition:
- Shared package NanoCore_pkg: reuse lsu_ctl_t and wb_entry_t. Add an lsu_state_t enum {IDLE, REQ, RD_WAIT, WB} and the localparam LSU_TIMEOUT_DEFAULT = 255.
- One sub-module: nanocore_lsu_ldext, a combinational align/extend function (rdata, addr[1:0], is_lb, is_lh, is_lu → 32-bit result). It is reused by the future store-to-load forwarder.

Test Plan:
- lw, addr 0x104, uid 0x12, rf_dst 5; gnt after 1 cycle; rdata 0xDEADBEEF → o_wb = {1, 0x12, 5, 0xDEADBEEF} on the 3rd cycle after accept.
- lb, addr 0x103, is_lu = 0; rdata 0x80FF_0000 → rf_wdata 0xFFFFFF80. lbu at the same address → 0x00000080.
- sh, addr 0x202, wdata 0x0000ABCD, wstrb 4'b1100 → o_dmem_wdata 0xABCD0000, o_dmem_addr 0x200. Writeback has rf_dst 0.
- i_wb_ready held low 5 cycles → o_wb stable and o_req_ready = 0 throughout. A new request is accepted the cycle after the wb handshake.
- gnt never asserted, TIMEOUT_CYC = 4 → o_err pulses once, then wb with data 0; FSM returns to IDLE.
- Reset asserted in RD_WAIT, then rvalid arrives after release → no wb issued; all outputs 0; next request completes normally.
